// File: rtl/beam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : beam_pkg
// Purpose  : Shared beam-domain types and constants (loader, scanner, selector).
// Revision : 1.0 - initial release
// ============================================================================
package beam_pkg;

    localparam int CW_ANTS  = 32;
    localparam int CW_WIDTH = 32;
    localparam int CW_DEPTH = 64;
    localparam int LAT      = 5;

    typedef struct packed {
        logic signed [15:0] q;
        logic signed [15:0] i;
    } cplx16_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // |y|^2 peaks at 2^31 (both parts at -32768), so the unsigned sum never wraps
    function automatic logic [31:0] cplx_pwr(input cplx16_t y);
        logic signed [31:0] re2;
        logic signed [31:0] im2;
        re2 = 32'($signed(y.i)) * 32'($signed(y.i));
        im2 = 32'($signed(y.q)) * 32'($signed(y.q));
        return $unsigned(re2) + $unsigned(im2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/beam_pwr_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : beam_pwr_scan_if
// Purpose  : Antenna-domain RE vector handshake into the beam power scanner.
// Revision : 1.0 - initial release
// ============================================================================
interface beam_pwr_scan_if #(
    parameter int ANTS = beam_pkg::CW_ANTS,
    parameter int IW   = 16
);
    logic [2*IW*ANTS-1:0] i_data;
    logic                 i_sel_odd;
    logic                 i_dvalid;
    logic                 o_ready;

    modport master (output i_data, i_sel_odd, i_dvalid, input  o_ready);
    modport slave  (input  i_data, i_sel_odd, i_dvalid, output o_ready);
endinterface
`default_nettype wire

// File: rtl/cplx_dot_tree.sv
`default_nettype none
// ============================================================================
// Module   : cplx_dot_tree
// Purpose  : Conjugate complex dot product, two-level adder tree, round/sat.
//            Fixed 3-cycle latency from i_w/i_x to y_o.
// Revision : 1.0 - initial release
// ============================================================================
module cplx_dot_tree
    import beam_pkg::*;
#(
    parameter int ANTS  = CW_ANTS,
    parameter int WIDTH = CW_WIDTH,
    parameter int IW    = 16,
    parameter int DROP  = 16
) (
    input  logic                    clk_i,
    input  logic [WIDTH*ANTS-1:0]   w_i,
    input  logic [2*IW*ANTS-1:0]    x_i,
    output cplx16_t                 y_o
);
    localparam int WW   = WIDTH / 2;
    localparam int PW   = WW + IW + 1;
    localparam int NGRP = (ANTS >= 4) ? 4 : 1;
    localparam int GSZ  = ANTS / NGRP;
    localparam int SW   = PW + $clog2(ANTS);
    localparam logic signed [SW-1:0] RND     = SW'(1) << (DROP - 1);
    localparam logic signed [SW-1:0] SAT_MAX = SW'(32767);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-32768);

    logic [ANTS-1:0][PW-1:0] re_p_d, im_p_d, re_p_q, im_p_q;
    logic [NGRP-1:0][SW-1:0] grp_re_d, grp_im_d, grp_re_q, grp_im_q;
    logic signed [SW-1:0]    sum_re, sum_im, rnd_re, rnd_im;

    function automatic logic signed [15:0] sat16(input logic signed [SW-1:0] v);
        if (v > SAT_MAX)
            return 16'sh7fff;
        else if (v < SAT_MIN)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    // conj(w)*x = (wr*xr + wi*xi) + j(wr*xi - wi*xr)
    for (genvar a = 0; a < ANTS; a++) begin : g_mul
        logic signed [PW-1:0] wr, wi, xr, xi;
        assign wr = PW'($signed(w_i[WIDTH*a      +: WW]));
        assign wi = PW'($signed(w_i[WIDTH*a + WW +: WW]));
        assign xr = PW'($signed(x_i[2*IW*a       +: IW]));
        assign xi = PW'($signed(x_i[2*IW*a + IW  +: IW]));
        assign re_p_d[a] = wr * xr + wi * xi;
        assign im_p_d[a] = wr * xi - wi * xr;
    end

    always_comb begin
        grp_re_d = '0;
        grp_im_d = '0;
        for (int g = 0; g < NGRP; g++) begin
            for (int k = 0; k < GSZ; k++) begin
                grp_re_d[g] = grp_re_d[g] + SW'($signed(re_p_q[g*GSZ+k]));
                grp_im_d[g] = grp_im_d[g] + SW'($signed(im_p_q[g*GSZ+k]));
            end
        end
    end

    // Round half-up: bias then arithmetic shift, so exact halves go toward +inf
    always_comb begin
        sum_re = '0;
        sum_im = '0;
        for (int g = 0; g < NGRP; g++) begin
            sum_re = sum_re + $signed(grp_re_q[g]);
            sum_im = sum_im + $signed(grp_im_q[g]);
        end
        rnd_re = (sum_re + RND) >>> DROP;
        rnd_im = (sum_im + RND) >>> DROP;
    end

    always_ff @(posedge clk_i) begin
        re_p_q   <= re_p_d;
        im_p_q   <= im_p_d;
        grp_re_q <= grp_re_d;
        grp_im_q <= grp_im_d;
        y_o.i    <= sat16(rnd_re);
        y_o.q    <= sat16(rnd_im);
    end

endmodule
`default_nettype wire

// File: rtl/beam_pwr_scan.sv
`default_nettype none
// ============================================================================
// Module   : beam_pwr_scan
// Purpose  : Scans all DEPTH beams of the selected codeword table per accepted
//            RE vector, one beam per cycle, streaming |y|^2 at LAT = 5.
//            Optional argmax tracker under `BEAM_SCAN_MAXTRACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module beam_pwr_scan
    import beam_pkg::*;
#(
    parameter int ANTS  = CW_ANTS,
    parameter int WIDTH = CW_WIDTH,
    parameter int DEPTH = CW_DEPTH,
    parameter int IW    = 16,
    parameter int DROP  = 16
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic [DEPTH-1:0][WIDTH*ANTS-1:0]     i_cw_even,
    input  logic [DEPTH-1:0][WIDTH*ANTS-1:0]     i_cw_odd,
    input  logic                                 i_cw_valid,
    beam_pwr_scan_if.slave                       vec,
    output logic [$clog2(DEPTH)-1:0]             o_beam_idx,
    output logic [31:0]                          o_beam_pwr,
    output logic                                 o_pvalid,
`ifdef BEAM_SCAN_MAXTRACK_EN
    output logic [$clog2(DEPTH)-1:0]             o_max_idx,
    output logic [31:0]                          o_max_pwr,
`endif
    output logic                                 o_last
);
    localparam int IDXW = $clog2(DEPTH);
    localparam int PIPE = LAT - 2;

    scan_state_t              state_q;
    logic [IDXW-1:0]          cnt_q;
    logic [2*IW*ANTS-1:0]     x_q;
    logic                     sel_q;
    logic                     ready_d, accept_d, last_beam_d;
    logic [WIDTH*ANTS-1:0]    cw_d;
    cplx16_t                  y;
    logic [31:0]              pwr_d;
    logic [PIPE-1:0]          vld_q;
    logic [PIPE-1:0][IDXW-1:0] idx_q;

    assign last_beam_d = (cnt_q == IDXW'(DEPTH - 1));
    assign ready_d     = i_cw_valid & ((state_q == IDLE) | last_beam_d);
    assign accept_d    = vec.i_dvalid & ready_d;
    assign vec.o_ready = ready_d;

    // An accept on the final beam reloads the vector in place: no bubble
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            sel_q   <= 1'b0;
        end else if (accept_d) begin
            state_q <= SCAN;
            cnt_q   <= '0;
            x_q     <= vec.i_data;
            sel_q   <= vec.i_sel_odd;
        end else begin
            case (state_q)
                IDLE: state_q <= IDLE;
                SCAN: begin
                    if (last_beam_d)
                        state_q <= IDLE;
                    else
                        cnt_q <= cnt_q + IDXW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cw_d = sel_q ? i_cw_odd[cnt_q] : i_cw_even[cnt_q];

    cplx_dot_tree #(
        .ANTS  (ANTS),
        .WIDTH (WIDTH),
        .IW    (IW),
        .DROP  (DROP)
    ) u_dot (
        .clk_i (i_clk),
        .w_i   (cw_d),
        .x_i   (x_q),
        .y_o   (y)
    );

    assign pwr_d = cplx_pwr(y);

    // Beam index/valid ride alongside the dot-product tree
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_q      <= '0;
            idx_q      <= '0;
            o_pvalid   <= 1'b0;
            o_last     <= 1'b0;
            o_beam_idx <= '0;
            o_beam_pwr <= '0;
        end else begin
            vld_q      <= {vld_q[PIPE-2:0], state_q == SCAN};
            idx_q      <= {idx_q[PIPE-2:0], cnt_q};
            o_pvalid   <= vld_q[PIPE-1];
            o_last     <= vld_q[PIPE-1] & (idx_q[PIPE-1] == IDXW'(DEPTH - 1));
            o_beam_idx <= vld_q[PIPE-1] ? idx_q[PIPE-1] : '0;
            o_beam_pwr <= vld_q[PIPE-1] ? pwr_d : '0;
        end
    end

`ifdef BEAM_SCAN_MAXTRACK_EN
    // Strict compare keeps the lowest index on ties; beam 0 re-arms
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_max_idx <= '0;
            o_max_pwr <= '0;
        end else if (vld_q[PIPE-1] &&
                     ((idx_q[PIPE-1] == '0) || (pwr_d > o_max_pwr))) begin
            o_max_idx <= idx_q[PIPE-1];
            o_max_pwr <= pwr_d;
        end
    end
`endif

endmodule
`default_nettype wire
